whack_a_mole_core: RTL and testbench
====================================

# whack_a_mole_core

Parametrised game controller for the whack-a-mole design. It handles difficulty selection, an LFSR-driven mole position over NUM_HOLES holes, per-mole and per-game millisecond timers, switch-edge hit detection and saturating scoring. It sits between the board button/switch inputs and the VGA/seven-segment display logic, which consume `mole_onehot`, `score`, `time_left` and `state`.

## Interface
- NUM_HOLES, 9: number of holes and switches (2..16).
- SCORE_W, 7: score width.
- TICK_DIV, 100000: Clk cycles per ms tick (100 MHz).
- GAME_MS, 60000: game length in ms.
- MOLE_MS_EASY / MOLE_MS_MED / MOLE_MS_HARD, 3000 / 2000 / 1000: mole lifetime in ms.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high.
- BtnC  in  1  start, and acknowledge on the game-over screen. Pre-debounced, level.
- BtnL / BtnU / BtnR  in  1 each  select easy / medium / hard.
- Sw  in  NUM_HOLES  hole switches. Pre-debounced.
- mole_onehot  out  NUM_HOLES  visible mole. Zero outside ACTIVE.
- mole_idx  out  4  current mole index.
- score  out  SCORE_W  current score.
- time_left  out  16  remaining game ms.
- state  out  5  one-hot state.
- hit_pulse  out  1  one-cycle pulse per scored hit.
- game_over  out  1  high in DONE.

## Operation
- States, one-hot: IDLE=00001, SELECT=00010, ACTIVE=00100, HIT=01000, DONE=10000.
- IDLE → SELECT on BtnC.
- SELECT → ACTIVE only when exactly one of BtnL/BtnU/BtnR is high.
  - Latches the mole period (EASY/MED/HARD).
  - Clears score.
  - Loads time_left=GAME_MS.
  - Spawns the first mole.
  - Zero or more than one button high: stay in SELECT.
- ACTIVE:
  - Rising edge on Sw[mole_idx] → HIT.
  - Mole timer expiry → respawn and stay in ACTIVE.
  - time_left reaching 0 → DONE.
- HIT:
  - score += 1, saturating at 2^SCORE_W−1.
  - hit_pulse=1.
  - Respawn, then → ACTIVE, or → DONE if time_left==0.
- DONE: score and mole_idx frozen, mole_onehot=0. BtnC → IDLE. Score stays valid until the next SELECT→ACTIVE.
- Switch edge: `sw_q` registers Sw every cycle. rise = Sw & ~sw_q. A held switch never re-scores.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle in every state.
  - Candidate = lfsr[15:0] mod NUM_HOLES.
  - If candidate equals current mole_idx, use (candidate+1) mod NUM_HOLES, so no immediate repeat.
- Respawn loads the new index and clears the mole ms counter.
- Other states: the game and mole timers hold their values.

## Timing
- Reset values: state=IDLE, mole_onehot=0, mole_idx=0, score=0, time_left=0, hit_pulse=0, game_over=0, lfsr=LFSR_SEED, sw_q=0, all counters=0.
- All outputs are registered. The state change is visible the cycle after the qualifying input edge.
- Tick: prescaler counts 0..TICK_DIV−1 in ACTIVE and HIT only. tick=1 on wrap.
- On each tick:
  - time_left decrements, stopping at 0.
  - mole counter increments.
  - Mole expiry when mole counter == period−1 on a tick.
- Hit latency:
  - Sw rise at cycle N → HIT at N+1.
  - score incremented and hit_pulse at N+2.
  - New mole visible at N+2.
- Simultaneous events, in priority order:
  1. Game expiry beats a hit: no score, → DONE.
  2. A hit beats mole expiry.
  3. Wrong-switch rises in the same cycle as a correct hit are ignored.
- Reset mid-game aborts to IDLE immediately. Nothing persists.

## Configuration
- MOLE_MISS_PENALTY_EN defined:
  - In ACTIVE, a rising edge on any Sw bit other than mole_idx decrements score by 1, saturating at 0.
  - One penalty per cycle, however many wrong switches rise.
  - Mole expiry without a hit also decrements by 1.
- Undefined: wrong switches and expiries have no effect on score.

## Test plan
Bench parameters: TICK_DIV=4, GAME_MS=40, MOLE_MS_EASY=5, MOLE_MS_MED=3, MOLE_MS_HARD=2, NUM_HOLES=9.
- Reset held, then released → state=00001, score=0, mole_onehot=0, time_left=0.
- BtnC, then BtnL+BtnR together, then BtnU alone → stays SELECT on the pair. ACTIVE on BtnU. time_left=40. Mole respawns every 12 cycles to a different index.
- In ACTIVE, raise Sw[mole_idx] and hold it for 20 cycles → exactly one hit_pulse, score=1, new mole_idx ≠ old.
- 130 correct hits with SCORE_W=7 → score saturates at 127.
- Hit edge on the same cycle time_left reaches 0 → DONE, score unchanged. BtnC → IDLE with score held.
- With MOLE_MISS_PENALTY_EN:
  - Score 2, two wrong switches raised together → score 1.
  - Two mole expiries → score 0, not wrap.
  - Without the macro, the same stimulus → score 2.

Source files
------------

// File: rtl/whack_a_mole_core.sv
// whack_a_mole_core: game FSM, LFSR mole placement, ms timers, switch-edge hits and scoring.
// Optional feature macro: MOLE_MISS_PENALTY_EN (wrong switches and missed moles cost one point).
module whack_a_mole_core #(
  parameter int          NUM_HOLES    = 9,
  parameter int          SCORE_W      = 7,
  parameter int          TICK_DIV     = 100000,
  parameter int          GAME_MS      = 60000,
  parameter int          MOLE_MS_EASY = 3000,
  parameter int          MOLE_MS_MED  = 2000,
  parameter int          MOLE_MS_HARD = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 BtnC,
  input  logic                 BtnL,
  input  logic                 BtnU,
  input  logic                 BtnR,
  input  logic [NUM_HOLES-1:0] Sw,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic [3:0]           mole_idx,
  output logic [SCORE_W-1:0]   score,
  output logic [15:0]          time_left,
  output logic [4:0]           state,
  output logic                 hit_pulse,
  output logic                 game_over
);
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    SELECT = 5'b00010,
    ACTIVE = 5'b00100,
    HIT    = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t                 state_reg, state_next;
  logic [15:0]            lfsr_reg;
  logic [NUM_HOLES-1:0]   sw_q;
  logic [PRESC_W-1:0]     presc_reg, presc_next;
  logic [15:0]            mole_cnt_reg, mole_cnt_next;
  logic [15:0]            period_reg, period_next;
  logic [3:0]             idx_next;
  logic [SCORE_W-1:0]     score_next;
  logic [15:0]            time_next;
  logic [NUM_HOLES-1:0]   onehot_next;

  logic                   lfsr_fb;
  logic [3:0]             cand, spawn_idx;
  logic [NUM_HOLES-1:0]   rise;
  logic [15:0]            rise_ext;
  logic                   running, tick, game_end, mole_exp, hit_rise, start_ok;

  // Fibonacci taps 16,14,13,11
  assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign cand      = 4'(lfsr_reg % 16'(NUM_HOLES));
  assign spawn_idx = (cand != mole_idx) ? cand :
                     (cand == 4'(NUM_HOLES - 1)) ? 4'd0 : cand + 4'd1;

  assign rise      = Sw & ~sw_q;
  assign rise_ext  = 16'(rise);
  assign hit_rise  = rise_ext[mole_idx];
  assign running   = (state_reg == ACTIVE) || (state_reg == HIT);
  assign tick      = running && (presc_reg == PRESC_W'(TICK_DIV - 1));
  assign game_end  = tick && (time_left <= 16'd1);
  assign mole_exp  = tick && (mole_cnt_reg == period_reg - 16'd1);
  assign start_ok  = ({BtnL, BtnU, BtnR} == 3'b100) ||
                     ({BtnL, BtnU, BtnR} == 3'b010) ||
                     ({BtnL, BtnU, BtnR} == 3'b001);

`ifdef MOLE_MISS_PENALTY_EN
  logic wrong_rise;
  // In ACTIVE the registered one-hot marks the live hole, so anything else rising is a miss.
  assign wrong_rise = |(rise & ~mole_onehot);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HOLES; gi++) begin : g_onehot
      assign onehot_next[gi] = (state_next == ACTIVE) && (idx_next == 4'(gi));
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    idx_next      = mole_idx;
    score_next    = score;
    time_next     = time_left;
    presc_next    = presc_reg;
    mole_cnt_next = mole_cnt_reg;
    period_next   = period_reg;

    if (running) begin
      presc_next = tick ? '0 : presc_reg + PRESC_W'(1);
      if (tick) begin
        time_next     = (time_left != 16'd0) ? time_left - 16'd1 : 16'd0;
        mole_cnt_next = mole_cnt_reg + 16'd1;
      end
    end

    case (state_reg)
      IDLE: if (BtnC) state_next = SELECT;
      SELECT: begin
        if (start_ok) begin
          period_next   = BtnL ? 16'(MOLE_MS_EASY) : BtnU ? 16'(MOLE_MS_MED) : 16'(MOLE_MS_HARD);
          score_next    = '0;
          time_next     = 16'(GAME_MS);
          presc_next    = '0;
          mole_cnt_next = '0;
          idx_next      = spawn_idx;
          state_next    = ACTIVE;
        end
      end
      ACTIVE: begin
        // Game expiry outranks a hit, which outranks mole expiry.
        if (game_end) begin
          state_next = DONE;
        end else if (hit_rise) begin
          state_next = HIT;
        end else begin
          if (mole_exp) begin
            idx_next      = spawn_idx;
            mole_cnt_next = '0;
          end
`ifdef MOLE_MISS_PENALTY_EN
          if ((wrong_rise || mole_exp) && (score != '0))
            score_next = score - SCORE_W'(1);
`endif
        end
      end
      HIT: begin
        score_next    = (score == SCORE_MAX) ? score : score + SCORE_W'(1);
        idx_next      = spawn_idx;
        mole_cnt_next = '0;
        state_next    = game_end ? DONE : ACTIVE;
      end
      DONE: if (BtnC) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= IDLE;
      lfsr_reg     <= LFSR_SEED;
      sw_q         <= '0;
      presc_reg    <= '0;
      mole_cnt_reg <= '0;
      period_reg   <= '0;
      mole_idx     <= '0;
      score        <= '0;
      time_left    <= '0;
      mole_onehot  <= '0;
      hit_pulse    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= {lfsr_reg[14:0], lfsr_fb};
      sw_q         <= Sw;
      presc_reg    <= presc_next;
      mole_cnt_reg <= mole_cnt_next;
      period_reg   <= period_next;
      mole_idx     <= idx_next;
      score        <= score_next;
      time_left    <= time_next;
      mole_onehot  <= onehot_next;
      hit_pulse    <= (state_reg == HIT);
      game_over    <= (state_next == DONE);
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_whack_a_mole_core.sv
// Randomised bench for whack_a_mole_core against a per-cycle game model built from the game rules.
// A second instance with a long game is used only for the score saturation run.
module tb_whack_a_mole_core;
  localparam int NH   = 9;
  localparam int SCW  = 7;
  localparam int TD   = 4;
  localparam int GMS  = 40;
  localparam int MS_E = 5;
  localparam int MS_M = 3;
  localparam int MS_H = 2;
  localparam int SMAX = (1 << SCW) - 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset;
  logic btn_c, btn_l, btn_u, btn_r;
  logic [NH-1:0] sw;
  logic [NH-1:0] mole_onehot;
  logic [3:0] mole_idx;
  logic [SCW-1:0] score;
  logic [15:0] time_left;
  logic [4:0] state;
  logic hit_pulse, game_over;

  logic s_btn_c, s_btn_l;
  logic [NH-1:0] s_sw;
  logic [NH-1:0] s_mole_onehot;
  logic [3:0] s_mole_idx;
  logic [SCW-1:0] s_score;
  logic [15:0] s_time_left;
  logic [4:0] s_state;
  logic s_hit_pulse, s_game_over;

  whack_a_mole_core #(.NUM_HOLES(NH), .SCORE_W(SCW), .TICK_DIV(TD), .GAME_MS(GMS),
    .MOLE_MS_EASY(MS_E), .MOLE_MS_MED(MS_M), .MOLE_MS_HARD(MS_H), .LFSR_SEED(SEED)) dut (
    .Clk(Clk), .Reset(Reset), .BtnC(btn_c), .BtnL(btn_l), .BtnU(btn_u), .BtnR(btn_r),
    .Sw(sw), .mole_onehot(mole_onehot), .mole_idx(mole_idx), .score(score),
    .time_left(time_left), .state(state), .hit_pulse(hit_pulse), .game_over(game_over));

  whack_a_mole_core #(.NUM_HOLES(NH), .SCORE_W(SCW), .TICK_DIV(TD), .GAME_MS(400),
    .MOLE_MS_EASY(MS_E), .MOLE_MS_MED(MS_M), .MOLE_MS_HARD(MS_H), .LFSR_SEED(SEED)) u_sat (
    .Clk(Clk), .Reset(Reset), .BtnC(s_btn_c), .BtnL(s_btn_l), .BtnU(1'b0), .BtnR(1'b0),
    .Sw(s_sw), .mole_onehot(s_mole_onehot), .mole_idx(s_mole_idx), .score(s_score),
    .time_left(s_time_left), .state(s_state), .hit_pulse(s_hit_pulse), .game_over(s_game_over));

  typedef enum int {M_IDLE, M_SELECT, M_ACTIVE, M_HIT, M_DONE} mstate_t;
  mstate_t m_st;
  int m_score, m_time, m_presc, m_mcnt, m_period, m_idx;
  bit m_hit;
  logic [15:0] m_lfsr;
  logic [NH-1:0] m_swq;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] code_of(mstate_t s);
    case (s)
      M_IDLE:   return 5'b00001;
      M_SELECT: return 5'b00010;
      M_ACTIVE: return 5'b00100;
      M_HIT:    return 5'b01000;
      default:  return 5'b10000;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_advance(logic [15:0] x);
    int taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[t]) fb ^= x[taps[t] - 1];
    return {x[14:0], fb};
  endfunction

  function automatic int pick_mole();
    int c = int'(m_lfsr) % NH;
    return (c == m_idx) ? (c + 1) % NH : c;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_score = 0; m_time = 0; m_presc = 0; m_mcnt = 0;
    m_period = 0; m_idx = 0; m_hit = 0; m_lfsr = SEED; m_swq = '0;
  endtask

  // One clock of game rules applied to the inputs currently driven.
  task automatic model_step();
    logic [NH-1:0] rise;
    bit tick, gend, mexp;
    mstate_t nst;
    int nscore, ntime, npresc, nmcnt, nidx, nperiod;
    if (Reset) begin
      model_reset();
      return;
    end
    rise = sw & ~m_swq;
    tick = 0; gend = 0; mexp = 0;
    nst = m_st; nscore = m_score; ntime = m_time; npresc = m_presc;
    nmcnt = m_mcnt; nidx = m_idx; nperiod = m_period;
    if (m_st == M_ACTIVE || m_st == M_HIT) begin
      tick = (m_presc == TD - 1);
      npresc = tick ? 0 : m_presc + 1;
      if (tick) begin
        ntime = (m_time > 0) ? m_time - 1 : 0;
        nmcnt = m_mcnt + 1;
        mexp = (nmcnt == m_period);
        gend = (ntime == 0);
      end
    end
    case (m_st)
      M_IDLE: if (btn_c) nst = M_SELECT;
      M_SELECT: begin
        if (int'(btn_l) + int'(btn_u) + int'(btn_r) == 1) begin
          nperiod = btn_l ? MS_E : (btn_u ? MS_M : MS_H);
          nscore = 0; ntime = GMS; npresc = 0; nmcnt = 0;
          nidx = pick_mole();
          nst = M_ACTIVE;
        end
      end
      M_ACTIVE: begin
        if (gend) nst = M_DONE;
        else if (rise[m_idx]) nst = M_HIT;
        else begin
          if (mexp) begin
            nidx = pick_mole();
            nmcnt = 0;
          end
`ifdef MOLE_MISS_PENALTY_EN
          begin
            logic [NH-1:0] live;
            live = '0;
            live[m_idx] = 1'b1;
            if (((rise & ~live) != '0) || mexp) nscore = (m_score > 0) ? m_score - 1 : 0;
          end
`endif
        end
      end
      M_HIT: begin
        nscore = (m_score < SMAX) ? m_score + 1 : SMAX;
        nidx = pick_mole();
        nmcnt = 0;
        nst = gend ? M_DONE : M_ACTIVE;
      end
      default: if (btn_c) nst = M_IDLE;
    endcase
    m_hit = (m_st == M_HIT);
    m_st = nst; m_score = nscore; m_time = ntime; m_presc = npresc;
    m_mcnt = nmcnt; m_idx = nidx; m_period = nperiod;
    m_lfsr = lfsr_advance(m_lfsr);
    m_swq = sw;
  endtask

  task automatic compare_all();
    logic [NH-1:0] exp_oh;
    exp_oh = '0;
    if (m_st == M_ACTIVE) exp_oh[m_idx] = 1'b1;
    check_eq("state", state, code_of(m_st));
    check_eq("score", score, m_score);
    check_eq("time_left", time_left, m_time);
    check_eq("mole_idx", mole_idx, m_idx);
    check_eq("mole_onehot", mole_onehot, exp_oh);
    check_eq("hit_pulse", hit_pulse, m_hit);
    check_eq("game_over", game_over, m_st == M_DONE);
  endtask

  task automatic step_cycle();
    model_step();
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes, pulses, prev, old_idx, found, saved, a, b;
    Reset = 1'b1; btn_c = 0; btn_l = 0; btn_u = 0; btn_r = 0; sw = '0;
    s_btn_c = 0; s_btn_l = 0; s_sw = '0;
    model_reset();
    repeat (3) step_cycle();
    check_eq("rst_state", state, 5'b00001);
    check_eq("rst_score", score, 0);
    check_eq("rst_onehot", mole_onehot, 0);
    check_eq("rst_time", time_left, 0);
    check_eq("rst_sat_state", s_state, 5'b00001);
    Reset = 1'b0;
    step_cycle();

    btn_c = 1; step_cycle(); btn_c = 0;
    check_eq("to_select", state, 5'b00010);
    btn_l = 1; btn_r = 1; step_cycle(); step_cycle(); btn_l = 0; btn_r = 0;
    check_eq("pair_stays_select", state, 5'b00010);
    btn_u = 1; step_cycle(); btn_u = 0;
    check_eq("start_active", state, 5'b00100);
    check_eq("start_time", time_left, GMS);

    changes = 0;
    prev = mole_idx;
    repeat (25) begin
      step_cycle();
      if (mole_idx != prev) begin
        changes++;
        check_eq("respawn_repeat", mole_idx == prev[3:0], 0);
        prev = mole_idx;
      end
    end
    check_eq("respawn_count", changes, 2);

    old_idx = m_idx;
    sw = '0; sw[m_idx] = 1'b1;
    pulses = 0;
    step_cycle(); pulses += hit_pulse;
    check_eq("hit_state", state, 5'b01000);
    step_cycle(); pulses += hit_pulse;
    check_eq("hit_score", score, 1);
    check_eq("hit_new_mole", mole_idx == old_idx[3:0], 0);
    repeat (18) begin
      step_cycle(); pulses += hit_pulse;
    end
    check_eq("held_one_pulse", pulses, 1);

    repeat (60) begin
      case ($urandom_range(0, 3))
        0: sw = NH'($urandom);
        1: begin sw = '0; sw[m_idx] = 1'b1; end
        default: ;
      endcase
      step_cycle();
    end

    sw = '0;
    step_cycle();
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (m_st == M_ACTIVE && m_time == 1 && m_presc == TD - 1) found = 1;
      else step_cycle();
    end
    check_eq("end_window_found", found, 1);
    if (found == 1) begin
      saved = m_score;
      sw[m_idx] = 1'b1;
      step_cycle();
      check_eq("end_beats_hit_state", state, 5'b10000);
      check_eq("end_beats_hit_score", score, saved);
      check_eq("end_game_over", game_over, 1);
      step_cycle();
      check_eq("end_no_pulse", hit_pulse, 0);
      sw = '0;
      btn_c = 1; step_cycle(); btn_c = 0;
      check_eq("done_to_idle", state, 5'b00001);
      check_eq("idle_score_held", score, saved);
    end

    if (m_st != M_IDLE) begin
      Reset = 1'b1; step_cycle(); Reset = 1'b0; step_cycle();
    end
    btn_c = 1; step_cycle(); btn_c = 0;
    btn_r = 1; step_cycle(); btn_r = 0;
    check_eq("pen_start", state, 5'b00100);
    for (int h = 0; h < 2; h++) begin
      sw = '0; sw[m_idx] = 1'b1;
      step_cycle(); step_cycle();
    end
    check_eq("pen_two_hits", score, 2);
    sw = '0;
    step_cycle();
    a = (m_idx + 1) % NH;
    b = (m_idx + 2) % NH;
    sw[a] = 1'b1; sw[b] = 1'b1;
    step_cycle();
`ifdef MOLE_MISS_PENALTY_EN
    check_eq("pen_wrong_pair", score, 1);
`else
    check_eq("pen_wrong_pair", score, 2);
`endif
    repeat (20) step_cycle();
`ifdef MOLE_MISS_PENALTY_EN
    check_eq("pen_expiries_floor", score, 0);
`else
    check_eq("pen_expiries_floor", score, 2);
`endif

    Reset = 1'b1; sw = '0;
    step_cycle();
    check_eq("midgame_rst_state", state, 5'b00001);
    check_eq("midgame_rst_score", score, 0);
    check_eq("midgame_rst_time", time_left, 0);
    Reset = 1'b0;
    step_cycle();

    s_btn_c = 1; step_cycle(); s_btn_c = 0;
    s_btn_l = 1; step_cycle(); s_btn_l = 0;
    check_eq("sat_start", s_state, 5'b00100);
    for (int k = 1; k <= 130; k++) begin
      s_sw = '0;
      s_sw[s_mole_idx] = 1'b1;
      step_cycle(); step_cycle();
      check_eq("sat_score", s_score, (k < SMAX) ? k : SMAX);
      check_eq("sat_pulse", s_hit_pulse, 1);
    end
    check_eq("sat_final", s_score, SMAX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
